// File: rtl/accel_proto_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | accel_proto_pkg : shared constants for the accelerometer protocol |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package accel_proto_pkg;

   localparam logic [7:0] CMD_X    = 8'd120;
   localparam logic [7:0] CMD_Y    = 8'd121;
   localparam logic [7:0] CMD_Z    = 8'd122;
   localparam logic [7:0] HDR_BYTE = 8'h00;
   localparam int         REPLY_LEN = 3;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SEND     = 3'd1,
      WAIT_HDR = 3'd2,
      WAIT_LO  = 3'd3,
      WAIT_HI  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/query_timeout.sv
`default_nettype none
// +------------------------------------------------------------------+
// | query_timeout : saturating inter-byte watchdog counter            |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module query_timeout
   import accel_proto_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic CLK_50,
   input  logic iRSTN,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int            c_cntWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_cntWidth-1:0] c_term = c_cntWidth'(TIMEOUT_CYCLES - 1);

   logic [c_cntWidth-1:0] r_count;

   // Holds at the terminal count so a stalled peer cannot wrap it back to zero.
   always_ff @(posedge CLK_50) begin
      if (!iRSTN) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable && (r_count != c_term)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign expired = enable && (r_count == c_term);

endmodule
`default_nettype wire

// File: rtl/accel_query_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | accel_query_master : host side of the UART accelerometer query    |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module accel_query_master #(
   parameter logic [7:0] CMD_BASE       = accel_proto_pkg::CMD_X,
   parameter logic [7:0] HDR_BYTE       = accel_proto_pkg::HDR_BYTE,
   parameter int         TIMEOUT_CYCLES = 50000
) (
   input  logic        CLK_50,
   input  logic        iRSTN,
   input  logic        start,
   input  logic [1:0]  dim,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        rx_ready,
   input  logic [7:0]  rx_data,
   output logic        busy,
   output logic [15:0] sample,
   output logic [1:0]  sample_dim,
   output logic        sample_valid,
   output logic        hdr_err,
   output logic        timeout_err
);
   import accel_proto_pkg::*;

   state_t     r_state;
   logic [1:0] r_curDim;
   logic [1:0] r_rrPtr;
   logic [7:0] r_low;

   logic       w_waiting;
   logic       w_expired;
   logic       w_pulse;
   logic [1:0] w_reqDim;

   assign w_waiting = (r_state == WAIT_HDR) || (r_state == WAIT_LO) || (r_state == WAIT_HI);
   // A pulse marks the cycle busy fell; a start there must not be taken.
   assign w_pulse   = sample_valid | hdr_err | timeout_err;
   assign w_reqDim  = (dim == 2'd3) ? r_rrPtr : dim;

   query_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .CLK_50  (CLK_50),
      .iRSTN   (iRSTN),
      .clear   (rx_ready | ~w_waiting),
      .enable  (w_waiting),
      .expired (w_expired)
   );

   always_ff @(posedge CLK_50) begin
      if (!iRSTN) begin
         r_state      <= IDLE;
         r_curDim     <= 2'd0;
         r_rrPtr      <= 2'd0;
         r_low        <= 8'd0;
         tx_start     <= 1'b0;
         tx_data      <= 8'd0;
         busy         <= 1'b0;
         sample       <= 16'd0;
         sample_dim   <= 2'd0;
         sample_valid <= 1'b0;
         hdr_err      <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         tx_start     <= 1'b0;
         sample_valid <= 1'b0;
         hdr_err      <= 1'b0;
         timeout_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !w_pulse) begin
                  r_curDim <= w_reqDim;
                  if (dim == 2'd3) begin
                     r_rrPtr <= (r_rrPtr == 2'd2) ? 2'd0 : r_rrPtr + 2'd1;
                  end
                  busy    <= 1'b1;
                  r_state <= SEND;
               end
            end
            SEND: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  tx_data  <= CMD_BASE + {6'd0, r_curDim};
                  r_state  <= WAIT_HDR;
               end
            end
            WAIT_HDR: begin
               if (rx_ready) begin
                  if (rx_data == HDR_BYTE) begin
                     r_state <= WAIT_LO;
                  end else begin
                     hdr_err <= 1'b1;
                     busy    <= 1'b0;
                     r_state <= IDLE;
                  end
               end
            end
            WAIT_LO: begin
               if (rx_ready) begin
                  r_low   <= rx_data;
                  r_state <= WAIT_HI;
               end
            end
            WAIT_HI: begin
               if (rx_ready) begin
                  sample       <= {rx_data, r_low};
                  sample_dim   <= r_curDim;
                  sample_valid <= 1'b1;
                  busy         <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase

         // A byte arriving on the terminal count takes priority over the timeout.
         if (w_waiting && w_expired && !rx_ready) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            r_state     <= IDLE;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_accel_query_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_accel_query_master : directed bench for accel_query_master     |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_accel_query_master;

   localparam int c_to = 64;

   logic        CLK_50;
   logic        iRSTN;
   logic        start;
   logic [1:0]  dim;
   logic        tx_busy;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        rx_ready;
   logic [7:0]  rx_data;
   logic        busy;
   logic [15:0] sample;
   logic [1:0]  sample_dim;
   logic        sample_valid;
   logic        hdr_err;
   logic        timeout_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]  dim;
      logic [7:0]  hdr;
      logic [7:0]  lo;
      logic [7:0]  hi;
      logic [7:0]  cmd;
      logic        hdrErr;
      logic [15:0] expSample;
      logic [1:0]  expDim;
   } vec_t;

   vec_t vec[8];

   accel_query_master #(
      .TIMEOUT_CYCLES (c_to)
   ) dut (
      .CLK_50       (CLK_50),
      .iRSTN        (iRSTN),
      .start        (start),
      .dim          (dim),
      .tx_busy      (tx_busy),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .rx_ready     (rx_ready),
      .rx_data      (rx_data),
      .busy         (busy),
      .sample       (sample),
      .sample_dim   (sample_dim),
      .sample_valid (sample_valid),
      .hdr_err      (hdr_err),
      .timeout_err  (timeout_err)
   );

   initial CLK_50 = 1'b0;
   always #10 CLK_50 = ~CLK_50;

   function automatic logic [31:0] allOuts();
      return {1'b0, tx_start, tx_data, busy, sample, sample_dim, sample_valid, hdr_err, timeout_err};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK_50);
      #1;
   endtask

   task automatic startReq(input logic [1:0] d);
      dim   = d;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b);
      rx_data  = b;
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      rx_data  = 8'h00;
   endtask

   // Returns ticks from the start strobe to tx_start and the command byte seen.
   task automatic waitTx(output int lat, output logic [7:0] cmd);
      lat = 1;
      for (int i = 0; i < 300; i++) begin
         if (tx_start) break;
         tick();
         lat++;
      end
      chk("tx_start seen", {31'd0, tx_start}, 32'd1);
      cmd = tx_data;
      tick();
      chk("tx_start one cycle", {31'd0, tx_start}, 32'd0);
   endtask

   task automatic goodTxn(input logic [1:0] d, input logic [7:0] lo, input logic [7:0] hi,
                          input logic [7:0] expCmd);
      int         lat;
      logic [7:0] cmd;
      startReq(d);
      waitTx(lat, cmd);
      chk("command byte", {24'd0, cmd}, {24'd0, expCmd});
      sendByte(8'h00);
      tick();
      sendByte(lo);
      tick();
      sendByte(hi);
   endtask

   initial begin
      int         lat;
      logic [7:0] cmd;
      logic       seen;

      vec[0] = '{2'd1, 8'h00, 8'h34, 8'h12, 8'd121, 1'b0, 16'h1234, 2'd1};
      vec[1] = '{2'd3, 8'h00, 8'h01, 8'h00, 8'd120, 1'b0, 16'h0001, 2'd0};
      vec[2] = '{2'd3, 8'h00, 8'h02, 8'h00, 8'd121, 1'b0, 16'h0002, 2'd1};
      vec[3] = '{2'd3, 8'h00, 8'h03, 8'h00, 8'd122, 1'b0, 16'h0003, 2'd2};
      vec[4] = '{2'd3, 8'h00, 8'h04, 8'h00, 8'd120, 1'b0, 16'h0004, 2'd0};
      vec[5] = '{2'd2, 8'h05, 8'h00, 8'h00, 8'd122, 1'b1, 16'h0004, 2'd0};
      vec[6] = '{2'd0, 8'h00, 8'hAA, 8'h55, 8'd120, 1'b0, 16'h55AA, 2'd0};
      vec[7] = '{2'd3, 8'h00, 8'hFF, 8'h80, 8'd121, 1'b0, 16'h80FF, 2'd1};

      iRSTN    = 1'b0;
      start    = 1'b0;
      dim      = 2'd0;
      tx_busy  = 1'b0;
      rx_ready = 1'b0;
      rx_data  = 8'h00;
      tick();
      tick();
      chk("reset outputs", allOuts(), 32'd0);
      iRSTN = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         startReq(vec[i].dim);
         chk("busy after start", {31'd0, busy}, 32'd1);
         waitTx(lat, cmd);
         chk("start to tx_start latency", lat, 32'd2);
         chk("vector command", {24'd0, cmd}, {24'd0, vec[i].cmd});
         sendByte(vec[i].hdr);
         if (vec[i].hdrErr) begin
            chk("hdr_err pulse", {31'd0, hdr_err}, 32'd1);
            chk("busy after hdr_err", {31'd0, busy}, 32'd0);
            chk("no valid on hdr_err", {31'd0, sample_valid}, 32'd0);
         end else begin
            chk("no hdr_err on good hdr", {31'd0, hdr_err}, 32'd0);
            tick();
            sendByte(vec[i].lo);
            tick();
            sendByte(vec[i].hi);
            chk("sample_valid pulse", {31'd0, sample_valid}, 32'd1);
            chk("busy low at done", {31'd0, busy}, 32'd0);
            chk("sample_dim", {30'd0, sample_dim}, {30'd0, vec[i].expDim});
         end
         chk("sample", {16'd0, sample}, {16'd0, vec[i].expSample});
         tick();
         chk("pulses end", {29'd0, sample_valid, hdr_err, timeout_err}, 32'd0);
      end

      // start on the done cycle is dropped and the pointer stays at z
      goodTxn(2'd0, 8'h11, 8'h22, 8'd120);
      chk("sample 2211", {16'd0, sample}, 32'h2211);
      dim   = 2'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start on done cycle ignored", {31'd0, busy}, 32'd0);
      tick();
      chk("no tx after ignored start", {30'd0, tx_start, busy}, 32'd0);
      goodTxn(2'd3, 8'h21, 8'h43, 8'd122);
      chk("sample 4321", {16'd0, sample}, 32'h4321);
      chk("sample_dim z", {30'd0, sample_dim}, 32'd2);
      tick();

      // byte on the terminal count wins over the timeout
      startReq(2'd1);
      waitTx(lat, cmd);
      sendByte(8'h00);
      sendByte(8'h34);
      repeat (c_to - 1) tick();
      chk("no timeout before terminal", {31'd0, timeout_err}, 32'd0);
      sendByte(8'h12);
      chk("terminal byte valid", {31'd0, sample_valid}, 32'd1);
      chk("terminal byte no timeout", {31'd0, timeout_err}, 32'd0);
      chk("terminal sample", {16'd0, sample}, 32'h1234);
      tick();

      // silence after the low byte
      startReq(2'd0);
      waitTx(lat, cmd);
      sendByte(8'h00);
      sendByte(8'h34);
      seen = 1'b0;
      repeat (c_to - 1) begin
         tick();
         if (timeout_err) seen = 1'b1;
      end
      chk("no early timeout", {31'd0, seen}, 32'd0);
      tick();
      chk("timeout_err pulse", {31'd0, timeout_err}, 32'd1);
      chk("busy after timeout", {31'd0, busy}, 32'd0);
      chk("no valid on timeout", {31'd0, sample_valid}, 32'd0);
      chk("sample kept on timeout", {16'd0, sample}, 32'h1234);
      tick();
      chk("timeout one cycle", {31'd0, timeout_err}, 32'd0);

      // transmitter busy for 100 cycles, second start ignored
      tx_busy = 1'b1;
      startReq(2'd0);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         start = (i == 10);
         dim   = 2'd3;
         tick();
         if (tx_start) seen = 1'b1;
      end
      start = 1'b0;
      chk("no tx while tx_busy", {31'd0, seen}, 32'd0);
      chk("busy while waiting", {31'd0, busy}, 32'd1);
      tx_busy = 1'b0;
      tick();
      chk("delayed tx_start", {23'd0, tx_start, tx_data}, {23'd0, 1'b1, 8'd120});
      tick();
      chk("delayed tx_start one cycle", {31'd0, tx_start}, 32'd0);
      sendByte(8'h00);
      sendByte(8'h01);
      sendByte(8'h02);
      chk("sample after tx_busy", {14'd0, sample_valid, sample_dim, sample}, {14'd0, 1'b1, 2'd0, 16'h0201});
      seen = 1'b0;
      repeat (5) begin
         tick();
         if (tx_start || busy) seen = 1'b1;
      end
      chk("ignored start not queued", {31'd0, seen}, 32'd0);
      goodTxn(2'd3, 8'h10, 8'h20, 8'd120);
      chk("pointer after ignored start", {30'd0, sample_dim}, 32'd0);
      tick();

      // reset in WAIT_LO, then stray byte in IDLE
      startReq(2'd2);
      waitTx(lat, cmd);
      sendByte(8'h00);
      iRSTN = 1'b0;
      tick();
      chk("outputs after mid reset", allOuts(), 32'd0);
      iRSTN = 1'b1;
      tick();
      sendByte(8'h05);
      chk("stray byte no hdr_err", {30'd0, hdr_err, busy}, 32'd0);
      tick();
      chk("idle after stray byte", allOuts(), 32'd0);
      goodTxn(2'd3, 8'h78, 8'h56, 8'd120);
      chk("sample after reset", {14'd0, sample_valid, sample_dim, sample}, {14'd0, 1'b1, 2'd0, 16'h5678});
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
